iram_rd_arb: RTL

Two-requester arbiter for the second read port (port B) of the dual-port instruction RAM. The core load/store unit (requester 0) and the debug module (requester 1) both need word reads of instruction memory: LSU for constant/literal loads, debug for memory dump. Port A stays dedicated to instruction fetch. The block round-robins port B between the two requesters, tags each issued read, and routes the 1-cycle-latency data back to its owner. It stalls the port while a response is back-pressured, relying on the RAM output holding its value when its enable is low.

---
 rtl/iram_rd_arb_pkg.sv | 24 ++
 rtl/iram_rd_arb_rr_arb2.sv | 38 +++
 rtl/iram_rd_arb.sv | 89 ++++++++
 3 files changed

// File: rtl/iram_rd_arb_pkg.sv
// Shared types and helpers for the instruction-RAM port-B read arbiter.
package iram_rd_arb_pkg;

  typedef logic [31:0] inst_bus_t;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_e;

  // Same address-width rule the instruction RAM uses.
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/iram_rd_arb_rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the other requester on every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic       ptr_r;
  logic [1:0] gnt_s;

  // Grant selection: single requester wins outright, contention resolved by the pointer.
  always_comb begin
    gnt_s = 2'b00;
    if (!en) begin
      gnt_s = 2'b00;
    end else if (req == 2'b11) begin
      gnt_s = ptr_r ? 2'b10 : 2'b01;
    end else begin
      gnt_s = req;
    end
  end

  // Pointer update: prefer the loser next time, hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (gnt_s != 2'b00) begin
      ptr_r <= gnt_s[0];
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/iram_rd_arb.sv
// Port-B arbiter for the instruction RAM: LSU (m0) and debug (m1) share one read port,
// responses are tagged and returned one cycle after grant.
module iram_rd_arb
  import iram_rd_arb_pkg::*;
#(
  parameter  int RAM_DEPTH = 65536,
  localparam int AW        = clogb2(RAM_DEPTH - 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  input  logic            m1_req,
  input  logic [AW-1:0]   m1_addr,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  output inst_bus_t       rdata,
  output logic            ram_enb,
  output logic [AW-1:0]   ram_addrb,
  input  inst_bus_t       ram_doutb
);

  logic       rvalid_r;
  req_id_e    rtag_r;
  logic       tag_rready_s;
  logic       stall_s;
  logic       arb_en_s;
  logic [1:0] req_s;
  logic [1:0] gnt_s;

  // Stall while the pending response's owner is not ready; the RAM output then holds.
  always_comb begin
    tag_rready_s = 1'b0;
    if (rtag_r == REQ_M1) begin
      tag_rready_s = m1_rready;
    end else begin
      tag_rready_s = m0_rready;
    end
    stall_s  = rvalid_r & ~tag_rready_s;
    arb_en_s = ~stall_s;
    req_s    = {m1_req, m0_req};
  end

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_s),
    .en  (arb_en_s),
    .gnt (gnt_s)
  );

  // Port-B drive and response routing.
  always_comb begin
    m0_gnt  = gnt_s[0];
    m1_gnt  = gnt_s[1];
    ram_enb = gnt_s[0] | gnt_s[1];
    if (gnt_s[1]) begin
      ram_addrb = m1_addr;
    end else begin
      ram_addrb = m0_addr;
    end
    m0_rvalid = rvalid_r & (rtag_r == REQ_M0);
    m1_rvalid = rvalid_r & (rtag_r == REQ_M1);
    rdata     = ram_doutb;
  end

  // Response tracking; a stalled response is re-presented unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= 1'b0;
      rtag_r   <= REQ_M0;
    end else if (!stall_s) begin
      rvalid_r <= ram_enb;
      if (ram_enb) begin
        rtag_r <= req_id_e'(gnt_s[1]);
      end else begin
        rtag_r <= rtag_r;
      end
    end else begin
      rvalid_r <= rvalid_r;
      rtag_r   <= rtag_r;
    end
  end

endmodule
